// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with fetch and
//            memory handshakes, memory timeout, sticky halt, retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int                  OPCODE_W    = 4,
    parameter logic [OPCODE_W-1:0] OP_LOAD     = 4'b0001,
    parameter logic [OPCODE_W-1:0] OP_STORE    = 4'b0010,
    parameter logic [OPCODE_W-1:0] OP_JUMP     = 4'b0011,
    parameter logic [OPCODE_W-1:0] OP_BRANCH   = 4'b0100,
    parameter logic [OPCODE_W-1:0] OP_CP       = 4'b0111,
    parameter logic [OPCODE_W-1:0] OP_HALT     = 4'b1011,
    parameter int                  MEM_TIMEOUT = 15,
    parameter int                  CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic                format,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                sign,
    input  logic                cond,
    input  logic                mem_ready,
    output logic                fetch_req,
    output logic                cpin,
    output logic                cpout,
    output logic                mem_read,
    output logic                mem_write,
    output logic [1:0]          write_src,
    output logic                reg_write,
    output logic                branch,
    output logic                jump,
    output logic                halt,
    output logic                mem_err,
    output logic [CNT_W-1:0]    retired
);

    localparam int                 c_WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TMO_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_fmt;
    logic [OPCODE_W-1:0] r_op;
    logic                r_sign;
    logic [c_WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]    r_retired;
    logic                r_mem_err;
    logic [1:0]          r_write_src;

    logic                w_is_mem;
    logic                w_timeout;
    logic                w_retire;
    logic [1:0]          w_src_dec;

    always_comb begin
        w_is_mem  = (r_op == OP_LOAD) || (r_op == OP_STORE);
        w_timeout = (r_state == S_MEM) && !mem_ready && (r_wait == c_TMO_LAST);
        w_retire  = (r_state == S_EXEC) || (r_state == S_WB) ||
                    ((r_state == S_MEM) && mem_ready && (r_op == OP_STORE));
        w_src_dec = 2'd1;
        if (w_is_mem) begin
            w_src_dec = 2'd0;
        end else if ((r_op == OP_CP) || (r_op == OP_BRANCH) ||
                     (r_op == OP_JUMP) || (r_op == OP_HALT)) begin
            w_src_dec = r_fmt ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (instr_valid) w_next = S_DECODE;
            S_DECODE: begin
                if (r_op == OP_HALT)   w_next = S_HALTED;
                else if (w_is_mem)     w_next = S_MEM;
                else                   w_next = S_EXEC;
            end
            S_EXEC:   w_next = S_FETCH;
            S_MEM: begin
                // A late mem_ready still completes the access rather than timing out
                if (mem_ready)         w_next = (r_op == OP_LOAD) ? S_WB : S_FETCH;
                else if (w_timeout)    w_next = S_HALTED;
            end
            S_WB:     w_next = S_FETCH;
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_fmt       <= 1'b0;
            r_op        <= '0;
            r_sign      <= 1'b0;
            r_wait      <= '0;
            r_retired   <= '0;
            r_mem_err   <= 1'b0;
            r_write_src <= 2'd0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_FETCH) && instr_valid) begin
                r_fmt  <= format;
                r_op   <= opcode;
                r_sign <= sign;
            end
            if (r_state == S_DECODE) begin
                r_wait <= '0;
                // write_src only moves when an instruction reaches EXEC/MEM
                if (r_op != OP_HALT) r_write_src <= w_src_dec;
            end
            if ((r_state == S_MEM) && !mem_ready && !w_timeout) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_timeout) r_mem_err <= 1'b1;
            if (w_retire)  r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        fetch_req = (r_state == S_FETCH);
        cpin      = 1'b0;
        cpout     = 1'b0;
        jump      = 1'b0;
        branch    = 1'b0;
        reg_write = 1'b0;
        mem_read  = (r_state == S_MEM) && (r_op == OP_LOAD);
        mem_write = (r_state == S_MEM) && (r_op == OP_STORE);
        halt      = (r_state == S_HALTED);
        mem_err   = r_mem_err;
        write_src = r_write_src;
        retired   = r_retired;
        if (r_state == S_EXEC) begin
            if (r_op == OP_CP) begin
                cpout = r_sign;
                cpin  = !r_sign;
            end else if (r_op == OP_JUMP) begin
                jump = 1'b1;
            end else if (r_op == OP_BRANCH) begin
                branch = cond;
            end else begin
                reg_write = 1'b1;
            end
        end
        if (r_state == S_WB) reg_write = 1'b1;
    end

endmodule
`default_nettype wire
